// File: rtl/risk_pkg.sv
// rtl/risk_pkg.sv - shared widths, command codes and FSM states for the RISK dispatcher
package risk_pkg;

    localparam int ADDR_W   = 15;
    localparam int STRIDE_W = 14;
    localparam int REG_W    = 5;

    localparam logic [2:0] RISK_LOAD  = 3'b000;
    localparam logic [2:0] RISK_STORE = 3'b001;
    localparam logic [2:0] RISK_ZERO  = 3'b010;
    localparam logic [2:0] RISK_NOP   = 3'b111;

    typedef enum logic [1:0] {IDLE, BEAT, DONE} state_t;

    // Unknown command codes are issued as nop beats
    function automatic logic [2:0] risk_map_func(input logic [2:0] f);
        case (f)
            RISK_LOAD, RISK_STORE, RISK_ZERO: return f;
            default:                          return RISK_NOP;
        endcase
    endfunction

    function automatic logic risk_is_mem(input logic [2:0] f);
        return (f == RISK_LOAD) || (f == RISK_STORE);
    endfunction

endpackage

// File: rtl/risk_dispatch_agen.sv
// rtl/risk_dispatch_agen.sv - beat address/register/repeat generator (load on accept, advance per beat)
module risk_dispatch_agen
    import risk_pkg::*;
#(
    parameter int REP_W = 4
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              i_load,
    input  logic              i_adv,
    input  logic [REG_W-1:0]  i_reg,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [ADDR_W-1:0] i_step,
    input  logic [REP_W-1:0]  i_rep,
    output logic [REG_W-1:0]  o_reg,
    output logic [ADDR_W-1:0] o_addr,
    output logic [REP_W-1:0]  o_rep_left
);

    logic [REG_W-1:0]  r_reg;
    logic [ADDR_W-1:0] r_addr;
    logic [ADDR_W-1:0] r_step;
    logic [REP_W-1:0]  r_rep;

    // Address and register index wrap naturally at their widths
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_reg  <= '0;
            r_addr <= '0;
            r_step <= '0;
            r_rep  <= '0;
        end else if (i_load) begin
            r_reg  <= i_reg;
            r_addr <= i_addr;
            r_step <= i_step;
            r_rep  <= i_rep;
        end else if (i_adv) begin
            r_reg  <= r_reg + REG_W'(1);
            r_addr <= r_addr + r_step;
            r_rep  <= r_rep - REP_W'(1);
        end
    end

    assign o_reg      = r_reg;
    assign o_addr     = r_addr;
    assign o_rep_left = r_rep;

endmodule

// File: rtl/risk_dispatch.sv
// rtl/risk_dispatch.sv - RISK tile command sequencer; RISK_DISPATCH_PERF_EN adds beat/busy-cycle counters
module risk_dispatch
    import risk_pkg::*;
#(
    parameter int REP_W = 4,
    parameter int HOLD  = 4
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [2:0]          cmd_func,
    input  logic [REG_W-1:0]    cmd_reg,
    input  logic [ADDR_W-1:0]   cmd_addr,
    input  logic [ADDR_W-1:0]   cmd_step,
    input  logic [STRIDE_W-1:0] cmd_stride_x,
    input  logic [STRIDE_W-1:0] cmd_stride_y,
    input  logic [REP_W-1:0]    cmd_rep,
    output logic [2:0]          risk_func,
    output logic [REG_W-1:0]    risk_reg,
    output logic [ADDR_W-1:0]   risk_addr,
    output logic [STRIDE_W-1:0] risk_stride_x,
    output logic [STRIDE_W-1:0] risk_stride_y,
    output logic                busy,
    output logic                done
`ifdef RISK_DISPATCH_PERF_EN
    ,
    output logic [31:0]         perf_beats,
    output logic [31:0]         perf_cycles
`endif
);

    localparam int HOLD_W = (HOLD > 1) ? $clog2(HOLD) : 1;
    localparam logic [HOLD_W-1:0] HOLD_RELOAD = HOLD_W'(HOLD - 1);

    state_t              r_state;
    state_t              w_state_nxt;
    logic [HOLD_W-1:0]   r_hold;
    logic [2:0]          r_func;
    logic [STRIDE_W-1:0] r_stride_x;
    logic [STRIDE_W-1:0] r_stride_y;
    logic [REP_W-1:0]    w_rep_left;
    logic                w_accept;
    logic                w_adv;
    logic                w_last;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) r_state <= IDLE;
        else         r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_adv       = 1'b0;
        w_last      = 1'b0;
        case (r_state)
            IDLE: if (cmd_valid) begin
                w_accept    = 1'b1;
                w_state_nxt = BEAT;
            end
            BEAT: if (r_hold == '0) begin
                if (w_rep_left == '0) begin
                    w_last      = 1'b1;
                    w_state_nxt = DONE;
                end else begin
                    w_adv = 1'b1;
                end
            end
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Only load/store beats are stretched; zero and nop beats take one cycle
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_func     <= RISK_NOP;
            r_hold     <= '0;
            r_stride_x <= '0;
            r_stride_y <= '0;
        end else if (w_accept) begin
            r_func     <= risk_map_func(cmd_func);
            r_hold     <= risk_is_mem(cmd_func) ? HOLD_RELOAD : '0;
            r_stride_x <= cmd_stride_x;
            r_stride_y <= cmd_stride_y;
        end else if (w_last) begin
            r_func <= RISK_NOP;
        end else if (w_adv) begin
            r_hold <= risk_is_mem(r_func) ? HOLD_RELOAD : '0;
        end else if (r_state == BEAT) begin
            r_hold <= r_hold - HOLD_W'(1);
        end
    end

    risk_dispatch_agen #(
        .REP_W (REP_W)
    ) u_agen (
        .clk        (clk),
        .resetn     (resetn),
        .i_load     (w_accept),
        .i_adv      (w_adv),
        .i_reg      (cmd_reg),
        .i_addr     (cmd_addr),
        .i_step     (cmd_step),
        .i_rep      (cmd_rep),
        .o_reg      (risk_reg),
        .o_addr     (risk_addr),
        .o_rep_left (w_rep_left)
    );

    assign cmd_ready     = (r_state == IDLE);
    assign busy          = (r_state != IDLE);
    assign done          = (r_state == DONE);
    assign risk_func     = r_func;
    assign risk_stride_x = r_stride_x;
    assign risk_stride_y = r_stride_y;

`ifdef RISK_DISPATCH_PERF_EN
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            perf_beats  <= '0;
            perf_cycles <= '0;
        end else begin
            if ((w_accept || w_adv) && (perf_beats != '1)) perf_beats <= perf_beats + 32'd1;
            if (busy && (perf_cycles != '1))               perf_cycles <= perf_cycles + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_risk_dispatch.sv
// tb/tb_risk_dispatch.sv - directed self-checking bench for risk_dispatch
module tb_risk_dispatch;
    import risk_pkg::*;

    logic                clk = 1'b0;
    logic                resetn = 1'b0;
    logic                cmd_valid = 1'b0;
    logic                cmd_ready;
    logic [2:0]          cmd_func = '0;
    logic [REG_W-1:0]    cmd_reg = '0;
    logic [ADDR_W-1:0]   cmd_addr = '0;
    logic [ADDR_W-1:0]   cmd_step = '0;
    logic [STRIDE_W-1:0] cmd_stride_x = '0;
    logic [STRIDE_W-1:0] cmd_stride_y = '0;
    logic [3:0]          cmd_rep = '0;
    logic [2:0]          risk_func;
    logic [REG_W-1:0]    risk_reg;
    logic [ADDR_W-1:0]   risk_addr;
    logic [STRIDE_W-1:0] risk_stride_x;
    logic [STRIDE_W-1:0] risk_stride_y;
    logic                busy;
    logic                done;
`ifdef RISK_DISPATCH_PERF_EN
    logic [31:0]         perf_beats;
    logic [31:0]         perf_cycles;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    risk_dispatch #(.REP_W(4), .HOLD(4)) dut (
        .clk           (clk),
        .resetn        (resetn),
        .cmd_valid     (cmd_valid),
        .cmd_ready     (cmd_ready),
        .cmd_func      (cmd_func),
        .cmd_reg       (cmd_reg),
        .cmd_addr      (cmd_addr),
        .cmd_step      (cmd_step),
        .cmd_stride_x  (cmd_stride_x),
        .cmd_stride_y  (cmd_stride_y),
        .cmd_rep       (cmd_rep),
        .risk_func     (risk_func),
        .risk_reg      (risk_reg),
        .risk_addr     (risk_addr),
        .risk_stride_x (risk_stride_x),
        .risk_stride_y (risk_stride_y),
        .busy          (busy),
        .done          (done)
`ifdef RISK_DISPATCH_PERF_EN
        ,
        .perf_beats    (perf_beats),
        .perf_cycles   (perf_cycles)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic drive(input logic [2:0] f, input logic [4:0] r, input logic [14:0] a,
                         input logic [14:0] s, input logic [13:0] sx, input logic [13:0] sy,
                         input logic [3:0] rep);
        cmd_func     = f;
        cmd_reg      = r;
        cmd_addr     = a;
        cmd_step     = s;
        cmd_stride_x = sx;
        cmd_stride_y = sy;
        cmd_rep      = rep;
        cmd_valid    = 1'b1;
    endtask

    // Returns at the negedge following acceptance, where the first beat is visible
    task automatic issue(input logic [2:0] f, input logic [4:0] r, input logic [14:0] a,
                         input logic [14:0] s, input logic [13:0] sx, input logic [13:0] sy,
                         input logic [3:0] rep);
        @(negedge clk);
        drive(f, r, a, s, sx, sy, rep);
        check("ready_at_offer", 32'(cmd_ready), 32'd1);
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic expect_beats(input string tag, input int n, input int cyc, input logic [2:0] f,
                                input logic [4:0] r0, input logic [14:0] a0, input logic [14:0] step,
                                input logic [13:0] sx, input logic [13:0] sy);
        logic [4:0]  er;
        logic [14:0] ea;
        for (int i = 0; i < n * cyc; i++) begin
            er = r0 + 5'(i / cyc);
            ea = a0 + 15'(i / cyc) * step;
            check({tag, "_func"}, 32'(risk_func), 32'(f));
            check({tag, "_reg"},  32'(risk_reg),  32'(er));
            check({tag, "_addr"}, 32'(risk_addr), 32'(ea));
            check({tag, "_sx"},   32'(risk_stride_x), 32'(sx));
            check({tag, "_sy"},   32'(risk_stride_y), 32'(sy));
            check({tag, "_busy"}, 32'({busy, cmd_ready, done}), 32'b100);
            @(negedge clk);
        end
    endtask

    task automatic expect_done(input string tag);
        check({tag, "_done"}, 32'({done, busy, cmd_ready, risk_func}), {28'd0, 1'b1, 1'b1, 1'b0, 3'b111});
        @(negedge clk);
        check({tag, "_idle"}, 32'({done, busy, cmd_ready}), 32'b001);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1);
    end

    initial begin
        int k;
        // 1. reset values
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_func",  32'(risk_func), 32'h7);
        check("rst_ready", 32'(cmd_ready), 32'd1);
        check("rst_busy",  32'({busy, done}), 32'd0);
        check("rst_regaddr", 32'({risk_reg, risk_addr}), 32'd0);
        resetn = 1'b1;

        // 2. single load beat held 4 cycles
        issue(RISK_LOAD, 5'd1, 15'h0040, 15'h0, 14'h0, 14'h0, 4'd0);
        expect_beats("t2", 1, 4, RISK_LOAD, 5'd1, 15'h0040, 15'h0, 14'h0, 14'h0);
        expect_done("t2");

        // 3. store with address and register wrap
        issue(RISK_STORE, 5'd31, 15'h7FF0, 15'h0010, 14'h1234, 14'h2AAA, 4'd2);
        check("t3_b0_addr", 32'(risk_addr), 32'h7FF0);
        expect_beats("t3", 3, 4, RISK_STORE, 5'd31, 15'h7FF0, 15'h0010, 14'h1234, 14'h2AAA);
        expect_done("t3");

        // 4. zero beats, one cycle each
        issue(RISK_ZERO, 5'd4, 15'h0100, 15'h0003, 14'h3FFF, 14'h0001, 4'd3);
        expect_beats("t4", 4, 1, RISK_ZERO, 5'd4, 15'h0100, 15'h0003, 14'h3FFF, 14'h0001);
        expect_done("t4");

        // max repeat: 16 beats, register wraps 31->0
        issue(RISK_ZERO, 5'd30, 15'h7FFE, 15'h0001, 14'h0, 14'h0, 4'd15);
        expect_beats("tmax", 16, 1, RISK_ZERO, 5'd30, 15'h7FFE, 15'h0001, 14'h0, 14'h0);
        expect_done("tmax");

        // unknown code issues nop beats that still count
        issue(3'b101, 5'd2, 15'h0010, 15'h0001, 14'h0, 14'h0, 4'd1);
        expect_beats("tnop", 2, 1, RISK_NOP, 5'd2, 15'h0010, 15'h0001, 14'h0, 14'h0);
        expect_done("tnop");

        // 5. valid held through a busy command
        @(negedge clk);
        drive(RISK_LOAD, 5'd1, 15'h0040, 15'h0, 14'h0, 14'h0, 4'd0);
        @(negedge clk);
        drive(RISK_STORE, 5'd2, 15'h0200, 15'h0, 14'h0005, 14'h0006, 4'd0);
        for (int i = 0; i < 4; i++) begin
            check("t5_ready_busy", 32'({cmd_ready, risk_func, risk_addr}), {16'd0, 1'b0, 3'b000, 15'h0040});
            @(negedge clk);
        end
        check("t5_done", 32'({done, cmd_ready}), 32'b10);
        @(negedge clk);
        check("t5_ready_after", 32'({done, cmd_ready}), 32'b01);
        @(negedge clk);
        cmd_valid = 1'b0;
        check("t5_second_func", 32'(risk_func), 32'(RISK_STORE));
        check("t5_second_addr", 32'({risk_reg, risk_addr}), {12'd0, 5'd2, 15'h0200});
        check("t5_second_stride", 32'({risk_stride_x, risk_stride_y}), {4'd0, 14'h0005, 14'h0006});
        k = 0;
        while (!done && k < 20) begin
            @(negedge clk);
            k++;
        end
        check("t5_done_seen", 32'(done), 32'd1);
        check("t5_store_cycles", 32'(k), 32'd4);
        @(negedge clk);

        // 6. asynchronous reset during beat 2
        issue(RISK_STORE, 5'd31, 15'h7FF0, 15'h0010, 14'h1234, 14'h2AAA, 4'd2);
        repeat (5) @(negedge clk);
        check("t6_in_beat2", 32'({risk_reg, risk_addr}), 32'd0);
        #2 resetn = 1'b0;
        #1;
        check("t6_rst_func", 32'(risk_func), 32'h7);
        check("t6_rst_flags", 32'({busy, done, cmd_ready}), 32'b001);
        check("t6_rst_strides", 32'({risk_stride_x, risk_stride_y}), 32'd0);
`ifdef RISK_DISPATCH_PERF_EN
        check("t6_perf_beats",  perf_beats,  32'd0);
        check("t6_perf_cycles", perf_cycles, 32'd0);
`endif
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("t6_no_done", 32'({done, busy}), 32'd0);
        end
        resetn = 1'b1;
        issue(RISK_ZERO, 5'd9, 15'h0005, 15'h0, 14'h0007, 14'h0008, 4'd0);
        expect_beats("t6_fresh", 1, 1, RISK_ZERO, 5'd9, 15'h0005, 15'h0, 14'h0007, 14'h0008);
        expect_done("t6_fresh");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
